// File: rtl/dpram_seq_pkg.sv
// Shared encodings for the dual-port RAM burst sequencer: FSM states, grant ids
// and the round-robin pick between the write and read requesters.
package dpram_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    // A tie goes to whichever requester was not served last.
    function automatic logic rr_pick(input logic pend_wr,
                                     input logic pend_rd,
                                     input logic last_grant);
        if (pend_wr && pend_rd) begin
            return ~last_grant;
        end
        return pend_rd ? GRANT_RD : GRANT_WR;
    endfunction

endpackage

// File: rtl/dpram_trig_edge.sv
// Enable-gated rising-edge detector: turns a trigger level into a one-cycle
// request pulse. The history register only advances on enabled edges.
module dpram_trig_edge (
    input  logic clk,
    input  logic reset_x,
    input  logic enb,
    input  logic trig,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            prev_q <= 1'b0;
        end else if (enb) begin
            prev_q <= trig;
        end
    end

    assign pulse = enb & trig & ~prev_q;

endmodule

// File: rtl/dpram_burst_sequencer.sv
// Round-robin burst sequencer for one shared RAM port: a write requester and a
// read requester each get an address burst of programmable length.
module dpram_burst_sequencer
    import dpram_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_x,
    input  logic              clk_enable,
    input  logic              trig_wr,
    input  logic              trig_rd,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              clr_ovr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    output logic              rd_valid,
    output logic              grant_id,
    output logic              busy,
    output logic              burst_done,
    output logic              overrun,
    output logic              ce_out
);

    localparam int FL_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(RD_LAT - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              pend_wr_q, pend_wr_d;
    logic              pend_rd_q, pend_rd_d;
    logic              ovr_q, ovr_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              done_q, done_d;
    logic [RD_LAT-1:0] vpipe_q, vpipe_d;

    logic pulse_wr, pulse_rd;
    logic any_pend, pick, grant_fire;

    dpram_trig_edge u_edge_wr (
        .clk     (clk),
        .reset_x (reset_x),
        .enb     (clk_enable),
        .trig    (trig_wr),
        .pulse   (pulse_wr)
    );

    dpram_trig_edge u_edge_rd (
        .clk     (clk),
        .reset_x (reset_x),
        .enb     (clk_enable),
        .trig    (trig_rd),
        .pulse   (pulse_rd)
    );

    assign any_pend = pend_wr_q | pend_rd_q;
    assign pick     = rr_pick(pend_wr_q, pend_rd_q, last_q);

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q <= ST_IDLE;
        end else if (clk_enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    state_d = (burst_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == LEN_W'(1)) begin
                    state_d = (grant_q == GRANT_RD) ? ST_FLUSH : ST_DONE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FL_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_ptr_d  = addr_ptr_q;
        ram_addr_d  = ram_addr_q;
        cnt_d       = cnt_q;
        flush_cnt_d = flush_cnt_q;
        grant_d     = grant_q;
        last_d      = last_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        done_d      = 1'b0;
        grant_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    grant_fire = 1'b1;
                    addr_ptr_d = (pick == GRANT_RD) ? rd_base : wr_base;
                    cnt_d      = burst_len;
                    grant_d    = pick;
                    last_d     = pick;
                end
            end
            ST_RUN: begin
                ram_addr_d  = addr_ptr_q;
                we_d        = (grant_q == GRANT_WR);
                re_d        = (grant_q == GRANT_RD);
                addr_ptr_d  = addr_ptr_q + 1'b1;
                cnt_d       = cnt_q - 1'b1;
                flush_cnt_d = '0;
            end
            ST_FLUSH: flush_cnt_d = flush_cnt_q + 1'b1;
            ST_DONE:  done_d = 1'b1;
            default:  done_d = 1'b0;
        endcase
    end

    // A repeat pulse is flagged as overrun rather than queued twice.
    always_comb begin
        pend_wr_d = (pend_wr_q & ~(grant_fire & (pick == GRANT_WR))) | (pulse_wr & ~pend_wr_q);
        pend_rd_d = (pend_rd_q & ~(grant_fire & (pick == GRANT_RD))) | (pulse_rd & ~pend_rd_q);
        ovr_d     = ovr_q;
        if ((pulse_wr & pend_wr_q) | (pulse_rd & pend_rd_q)) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_vpipe
            if (gi == 0) begin : g_head
                assign vpipe_d[gi] = re_q;
            end else begin : g_tail
                assign vpipe_d[gi] = vpipe_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            addr_ptr_q  <= '0;
            ram_addr_q  <= '0;
            cnt_q       <= '0;
            flush_cnt_q <= '0;
            grant_q     <= GRANT_WR;
            last_q      <= GRANT_RD;
            pend_wr_q   <= 1'b0;
            pend_rd_q   <= 1'b0;
            ovr_q       <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            done_q      <= 1'b0;
            vpipe_q     <= '0;
        end else if (clk_enable) begin
            addr_ptr_q  <= addr_ptr_d;
            ram_addr_q  <= ram_addr_d;
            cnt_q       <= cnt_d;
            flush_cnt_q <= flush_cnt_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            pend_wr_q   <= pend_wr_d;
            pend_rd_q   <= pend_rd_d;
            ovr_q       <= ovr_d;
            we_q        <= we_d;
            re_q        <= re_d;
            done_q      <= done_d;
            vpipe_q     <= vpipe_d;
        end
    end

    // Held cycles must not present an access, so strobes are masked by the enable.
    assign ram_addr   = ram_addr_q;
    assign ram_we     = we_q & clk_enable;
    assign ram_re     = re_q & clk_enable;
    assign burst_done = done_q & clk_enable;
    assign rd_valid   = vpipe_q[RD_LAT-1];
    assign grant_id   = grant_q;
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = ovr_q;
    assign ce_out     = clk_enable;

endmodule
